// File: rtl/instruction_loader_if.sv
// Byte-stream in / instruction-memory write out bundle for the program loader.
// master: the side that requests loads and supplies bytes.
// slave: the loader itself.
interface instruction_loader_if #(
  parameter int unsigned mem_size   = 8,
  parameter int unsigned instr_size = 32
);
  logic                  start;
  logic [mem_size-1:0]   num_words;
  logic [7:0]            byte_data;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  mem_we;
  logic [mem_size-1:0]   mem_addr;
  logic [instr_size-1:0] mem_wdata;
  logic                  cpu_hold;
  logic                  done;
  logic                  error;

  modport master (
    output start, num_words, byte_data, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error
  );

  modport slave (
    input  start, num_words, byte_data, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error
  );
endinterface

// File: rtl/instruction_loader.sv
// Program loader: collects a little-endian byte stream into instruction words
// and writes them to consecutive instruction-memory addresses, holding the CPU
// fetch stage in reset until the whole program has landed.
module instruction_loader #(
  parameter int unsigned mem_size   = 8,
  parameter int unsigned instr_size = 32,
  parameter int unsigned pc_incr    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  instruction_loader_if.slave  bus
);

  localparam int unsigned Bpw  = instr_size / 8;
  localparam int unsigned IdxW = (Bpw > 1) ? $clog2(Bpw) : 1;
  // Largest program that fits the address space without overwriting itself.
  localparam longint unsigned MaxWords = (64'd1 << mem_size) / 64'(pc_incr);
  localparam logic [mem_size-1:0] AddrStep = mem_size'(pc_incr);
  localparam logic [IdxW-1:0]     LastIdx  = IdxW'(Bpw - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StWrite,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [mem_size-1:0]   num_words_q, num_words_d;
  logic [mem_size-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [instr_size-1:0] word_q, word_d;
  logic [mem_size-1:0]   addr_q, addr_d;
  logic                  err_q, err_d;
  logic                  ready_q, ready_d;
  logic                  we_q, we_d;
  logic                  hold_q, hold_d;
  logic                  done_q, done_d;
  logic                  byte_fire;

  // Next-state logic; outputs are decoded from the next state so that the
  // registered versions line up exactly with the state they describe.
  always_comb begin
    state_d     = state_q;
    num_words_d = num_words_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    word_d      = word_q;
    addr_d      = addr_q;
    err_d       = err_q;
    byte_fire   = bus.byte_valid && ready_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          num_words_d = bus.num_words;
          addr_d      = '0;
          cnt_d       = '0;
          idx_d       = '0;
          err_d       = 1'b0;
          if (bus.num_words == '0) begin
            state_d = StDone;
          end else if (64'(bus.num_words) > MaxWords) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StRecv;
          end
        end
      end
      StRecv: begin
        if (byte_fire) begin
          for (int unsigned k = 0; k < Bpw; k++) begin
            if (idx_q == IdxW'(k)) begin
              word_d[8*k +: 8] = bus.byte_data;
            end
          end
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = StWrite;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StWrite: begin
        // The write happens this cycle; step the pointer for the next word.
        addr_d  = addr_q + AddrStep;
        cnt_d   = cnt_q + mem_size'(1);
        state_d = (cnt_d == num_words_q) ? StDone : StRecv;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    ready_d = (state_d == StRecv);
    we_d    = (state_d == StWrite);
    done_d  = (state_d == StDone);
    hold_d  = (state_d != StDone);
  end

  // State and registered outputs, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      num_words_q <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      word_q      <= '0;
      addr_q      <= '0;
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
      we_q        <= 1'b0;
      hold_q      <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_words_q <= num_words_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
      we_q        <= we_d;
      hold_q      <= hold_d;
      done_q      <= done_d;
    end
  end

  assign bus.byte_ready = ready_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = word_q;
  assign bus.cpu_hold   = hold_q;
  assign bus.done       = done_q;
  assign bus.error      = err_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: random byte streams are loaded
// and every memory write is compared with words assembled from the stream.
module tb_instruction_loader;

  localparam int MemSize = 8;
  localparam int InstrSize = 32;
  localparam int PcIncr = 4;
  localparam int Budget = 2000;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  logic [7:0]  stream[$];
  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  instruction_loader_if #(.mem_size(MemSize), .instr_size(InstrSize)) bus ();

  instruction_loader #(
    .mem_size  (MemSize),
    .instr_size(InstrSize),
    .pc_incr   (PcIncr)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: one entry per cycle with mem_we high.
  always @(negedge clk) begin
    if (bus.mem_we) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
    end
  end

  function automatic logic [31:0] exp_word(input int w);
    return {stream[4*w+3], stream[4*w+2], stream[4*w+1], stream[4*w]};
  endfunction

  function automatic logic [7:0] exp_addr(input int w);
    return 8'((w * PcIncr) % 256);
  endfunction

  task automatic fill_random(input int n);
    stream.delete();
    for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom));
  endtask

  task automatic clear_writes();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.start = 1'b0;
    bus.byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Start a load of n words from `stream` and feed bytes until done.
  // gap_mode 0: valid always high, 1: every other cycle, 2: random.
  task automatic run_load(input int n, input int gap_mode, input int abort_after,
                          input bit pulse_start, output int cycles,
                          output int ready_drops, output int hold_early);
    int   idx;
    bit   want;
    logic accepted;
    logic prev_ready;
    idx = 0;
    cycles = 0;
    ready_drops = 0;
    hold_early = 0;
    bus.start = 1'b1;
    bus.num_words = 8'(n);
    @(negedge clk);
    bus.start = 1'b0;
    while (cycles < Budget) begin
      if (bus.done) break;
      if (abort_after > 0 && idx >= abort_after) break;
      if (gap_mode == 0) want = 1'b1;
      else if (gap_mode == 1) want = (cycles % 2 == 0);
      else want = 1'($urandom_range(0, 1));
      if (idx < stream.size() && want) begin
        bus.byte_valid = 1'b1;
        bus.byte_data = stream[idx];
      end else begin
        bus.byte_valid = 1'b0;
        bus.byte_data = 8'($urandom);
      end
      accepted = bus.byte_valid && bus.byte_ready;
      prev_ready = bus.byte_ready;
      if (pulse_start && cycles == 6) begin
        bus.start = 1'b1;
        bus.num_words = 8'd1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cycles++;
      if (accepted) idx++;
      if (prev_ready && !accepted && !bus.byte_ready) ready_drops++;
      if (!bus.done && !bus.cpu_hold) hold_early++;
    end
    bus.byte_valid = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (bus.cpu_hold !== 1'b1) begin n_bad++; $display("FAIL reset_hold got %b want 1", bus.cpu_hold); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_cmp++; if (bus.error !== 1'b0) begin n_bad++; $display("FAIL reset_error got %b want 0", bus.error); end
    n_cmp++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_we got %b want 0", bus.mem_we); end
    n_cmp++; if (bus.byte_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b want 0", bus.byte_ready); end
    n_cmp++; if (bus.mem_addr !== 8'h00) begin n_bad++; $display("FAIL reset_addr got %h want 00", bus.mem_addr); end
    n_cmp++; if (bus.mem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_wdata got %h want 0", bus.mem_wdata); end
  endtask

  task automatic test_directed(input int gap_mode);
    int cyc, drops, early;
    logic [7:0] b[8];
    b = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    stream.delete();
    for (int i = 0; i < 8; i++) stream.push_back(b[i]);
    clear_writes();
    run_load(2, gap_mode, 0, 1'b0, cyc, drops, early);
    if (gap_mode == 0) begin
      n_cmp++; if (cyc !== 10) begin n_bad++; $display("FAIL dir_latency got %0d want 10", cyc); end
    end else begin
      n_cmp++; if (drops !== 0) begin n_bad++; $display("FAIL gap_ready_drop got %0d want 0", drops); end
    end
    n_cmp++; if (bus.done !== 1'b1 || bus.cpu_hold !== 1'b0) begin n_bad++; $display("FAIL dir_done got done=%b hold=%b want 1/0", bus.done, bus.cpu_hold); end
    n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL dir_hold_early got %0d want 0", early); end
    n_cmp++; if (wr_addr.size() !== 2) begin n_bad++; $display("FAIL dir_nwrites got %0d want 2", wr_addr.size()); end
    if (wr_addr.size() >= 2) begin
      n_cmp++; if (wr_addr[0] !== 8'h00 || wr_data[0] !== 32'h00000013) begin n_bad++; $display("FAIL dir_w0 got %h@%h want 00000013@00", wr_data[0], wr_addr[0]); end
      n_cmp++; if (wr_addr[1] !== 8'h04 || wr_data[1] !== 32'h00100093) begin n_bad++; $display("FAIL dir_w1 got %h@%h want 00100093@04", wr_data[1], wr_addr[1]); end
    end
  endtask

  task automatic test_zero_and_oversize();
    int cyc, drops, early, n;
    stream.delete();
    clear_writes();
    run_load(0, 0, 0, 1'b0, cyc, drops, early);
    n_cmp++; if (cyc !== 0 || bus.done !== 1'b1 || bus.error !== 1'b0) begin n_bad++; $display("FAIL zero_words got cyc=%0d done=%b err=%b want 0/1/0", cyc, bus.done, bus.error); end
    run_load(65, 0, 0, 1'b0, cyc, drops, early);
    n_cmp++; if (cyc !== 0 || bus.done !== 1'b1 || bus.error !== 1'b1) begin n_bad++; $display("FAIL over65 got cyc=%0d done=%b err=%b want 0/1/1", cyc, bus.done, bus.error); end
    n = $urandom_range(66, 255);
    run_load(n, 0, 0, 1'b0, cyc, drops, early);
    n_cmp++; if (bus.error !== 1'b1 || bus.done !== 1'b1) begin n_bad++; $display("FAIL over_rand n=%0d got err=%b done=%b want 1/1", n, bus.error, bus.done); end
    n_cmp++; if (wr_addr.size() !== 0) begin n_bad++; $display("FAIL nowrite_reject got %0d want 0", wr_addr.size()); end
    fill_random(1);
    run_load(1, 0, 0, 1'b0, cyc, drops, early);
    n_cmp++; if (bus.error !== 1'b0 || bus.done !== 1'b1) begin n_bad++; $display("FAIL err_clear got err=%b done=%b want 0/1", bus.error, bus.done); end
    n_cmp++; if (wr_addr.size() !== 1) begin n_bad++; $display("FAIL after_err_nwrites got %0d want 1", wr_addr.size()); end
    else begin
      n_cmp++; if (wr_data[0] !== exp_word(0) || wr_addr[0] !== 8'h00) begin n_bad++; $display("FAIL after_err_w got %h@%h want %h@00", wr_data[0], wr_addr[0], exp_word(0)); end
    end
  endtask

  task automatic test_full();
    int cyc, drops, early, bad;
    fill_random(64);
    clear_writes();
    run_load(64, 0, 0, 1'b0, cyc, drops, early);
    n_cmp++; if (cyc !== 320) begin n_bad++; $display("FAIL full_latency got %0d want 320", cyc); end
    n_cmp++; if (bus.done !== 1'b1 || bus.error !== 1'b0) begin n_bad++; $display("FAIL full_done got done=%b err=%b want 1/0", bus.done, bus.error); end
    n_cmp++; if (bus.mem_addr !== 8'h00) begin n_bad++; $display("FAIL full_wrap got %h want 00", bus.mem_addr); end
    n_cmp++; if (wr_addr.size() !== 64) begin n_bad++; $display("FAIL full_nwrites got %0d want 64", wr_addr.size()); end
    else begin
      n_cmp++; if (wr_addr[63] !== 8'd252) begin n_bad++; $display("FAIL full_last_addr got %0d want 252", wr_addr[63]); end
      bad = 0;
      for (int w = 0; w < 64; w++) if (wr_addr[w] !== exp_addr(w) || wr_data[w] !== exp_word(w)) bad++;
      n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL full_words got %0d wrong want 0", bad); end
    end
  endtask

  task automatic test_mid_reset();
    int cyc, drops, early;
    fill_random(2);
    clear_writes();
    run_load(2, 0, 6, 1'b0, cyc, drops, early);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n_cmp++; if (bus.cpu_hold !== 1'b1 || bus.done !== 1'b0 || bus.byte_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_state got hold=%b done=%b rdy=%b want 1/0/0", bus.cpu_hold, bus.done, bus.byte_ready); end
    n_cmp++; if (bus.mem_addr !== 8'h00 || bus.mem_wdata !== 32'h0) begin n_bad++; $display("FAIL midrst_regs got addr=%h data=%h want 00/0", bus.mem_addr, bus.mem_wdata); end
    repeat (3) @(negedge clk);
    n_cmp++; if (wr_addr.size() !== 1) begin n_bad++; $display("FAIL midrst_nwrites got %0d want 1", wr_addr.size()); end
    fill_random(1);
    clear_writes();
    run_load(1, 0, 0, 1'b0, cyc, drops, early);
    n_cmp++; if (wr_addr.size() !== 1) begin n_bad++; $display("FAIL fresh_nwrites got %0d want 1", wr_addr.size()); end
    else begin
      n_cmp++; if (wr_addr[0] !== 8'h00 || wr_data[0] !== exp_word(0)) begin n_bad++; $display("FAIL fresh_w0 got %h@%h want %h@00", wr_data[0], wr_addr[0], exp_word(0)); end
    end
  endtask

  task automatic test_start_ignored();
    int cyc, drops, early, bad;
    fill_random(3);
    clear_writes();
    run_load(3, 0, 0, 1'b1, cyc, drops, early);
    n_cmp++; if (cyc !== 15) begin n_bad++; $display("FAIL ign_latency got %0d want 15", cyc); end
    n_cmp++; if (wr_addr.size() !== 3) begin n_bad++; $display("FAIL ign_nwrites got %0d want 3", wr_addr.size()); end
    else begin
      bad = 0;
      for (int w = 0; w < 3; w++) if (wr_addr[w] !== exp_addr(w) || wr_data[w] !== exp_word(w)) bad++;
      n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL ign_words got %0d wrong want 0", bad); end
    end
  endtask

  task automatic test_random();
    int cyc, drops, early, n, mode, bad;
    for (int it = 0; it < 9; it++) begin
      n = $urandom_range(1, 6);
      mode = it % 3;
      fill_random(n);
      clear_writes();
      run_load(n, mode, 0, 1'b0, cyc, drops, early);
      if (mode == 0) begin
        n_cmp++; if (cyc !== 5 * n) begin n_bad++; $display("FAIL rnd%0d_latency got %0d want %0d", it, cyc, 5 * n); end
      end
      n_cmp++; if (bus.done !== 1'b1 || bus.cpu_hold !== 1'b0 || drops !== 0) begin n_bad++; $display("FAIL rnd%0d_end got done=%b hold=%b drops=%0d want 1/0/0", it, bus.done, bus.cpu_hold, drops); end
      n_cmp++; if (wr_addr.size() !== n) begin n_bad++; $display("FAIL rnd%0d_nwrites got %0d want %0d", it, wr_addr.size(), n); end
      else begin
        bad = 0;
        for (int w = 0; w < n; w++) if (wr_addr[w] !== exp_addr(w) || wr_data[w] !== exp_word(w)) bad++;
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL rnd%0d_words got %0d wrong want 0", it, bad); end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.num_words = '0;
    bus.byte_data = '0;
    bus.byte_valid = 1'b0;
    @(negedge clk);
    do_reset();
    test_reset();
    test_directed(0);
    test_directed(1);
    test_zero_and_oversize();
    test_full();
    test_mid_reset();
    test_start_ignored();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 The block SHALL have parameter mem_size, default 8, giving the byte-address width of instruction memory.
REQ-002 The block SHALL have parameter instr_size, default 32, giving the instruction width in bits (a multiple of 8); BPW = instr_size/8 bytes per word.
REQ-003 The block SHALL have parameter pc_incr, default 4, giving the byte-address step between consecutive instructions.
REQ-004 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst  input  1  synchronous, active-low reset (rst=0 sampled at a rising edge resets the block).
REQ-006 The block SHALL have port start  input  1  one-cycle request to begin a program load.
REQ-007 The block SHALL have port num_words  input  mem_size  number of instructions to load; sampled only on an accepted start.
REQ-008 The block SHALL have port byte_data  input  8  incoming program byte.
REQ-009 The block SHALL have port byte_valid  input  1  byte_data is valid.
REQ-010 The block SHALL have port byte_ready  output  1  the loader accepts a byte this cycle.
REQ-011 The block SHALL have port mem_we  output  1  instruction-memory write strobe.
REQ-012 The block SHALL have port mem_addr  output  mem_size  instruction-memory byte address.
REQ-013 The block SHALL have port mem_wdata  output  instr_size  instruction word to write.
REQ-014 The block SHALL have port cpu_hold  output  1  holds the fetch stage in reset while high.
REQ-015 The block SHALL have port done  output  1  load complete.
REQ-016 The block SHALL have port error  output  1  last requested load was rejected as oversize.

Function
REQ-017 The FSM SHALL have states IDLE, RECV, WRITE and DONE.
REQ-018 In IDLE or DONE, start=1 SHALL latch num_words, clear mem_addr to 0, clear the word counter, byte index and error, set cpu_hold=1, and move to RECV next cycle.
REQ-019 On an accepted start with num_words=0, the FSM SHALL go directly to DONE with no writes.
REQ-020 On an accepted start with num_words > 2^mem_size/pc_incr (64 at defaults), the FSM SHALL set error=1 and go to DONE with no writes.
REQ-021 start SHALL be ignored in RECV and WRITE.
REQ-022 byte_ready SHALL be 1 only in RECV; a byte is accepted when byte_valid and byte_ready are both 1.
REQ-023 Accepted bytes SHALL be assembled little-endian: the byte at index k goes to word bits [8k+7:8k], for k=0..BPW-1.
REQ-024 On acceptance of byte index BPW-1, the FSM SHALL enter WRITE on the next cycle.
REQ-025 In WRITE, mem_we=1 for exactly one cycle, with mem_addr and mem_wdata stable for that cycle.
REQ-026 After WRITE, mem_addr SHALL advance by pc_incr, modulo 2^mem_size, and the word counter SHALL increment.
REQ-027 After WRITE, the FSM SHALL go to DONE if the word counter equals num_words, else return to RECV.
REQ-028 Gaps with byte_valid=0 SHALL stall RECV indefinitely, with no timeout and no state loss.
REQ-029 In DONE, done=1 and cpu_hold=0; the FSM remains in DONE until start.
REQ-030 mem_we SHALL be 0 in every state except WRITE.
REQ-031 done SHALL be 0 in every state except DONE.
REQ-032 Load latency for N>0 words with byte_valid held high SHALL be N*(BPW+1) cycles from entering RECV to entering DONE.

Reset
REQ-033 When rst=0 is sampled at a rising edge, in any state including mid-load, the block SHALL enter IDLE.
REQ-034 On that reset the block SHALL set cpu_hold=1, done=0, error=0, mem_we=0, byte_ready=0, mem_addr=0 and mem_wdata=0, and clear the counter and byte index.
REQ-035 A partially assembled word SHALL be discarded on reset and never written.
REQ-036 cpu_hold SHALL stay 1 in IDLE after reset until a load completes.

Verification
REQ-037 Reset then start with num_words=2 and bytes 13,00,00,00,93,00,10,00 streamed back-to-back -> writes 0x00000013@0 then 0x00100093@4, one mem_we pulse each; done=1 and cpu_hold=0 at cycle 10 after RECV entry.
REQ-038 Same load with byte_valid toggling every other cycle -> identical writes and data; byte_ready never drops in RECV; no extra mem_we pulses.
REQ-039 start with num_words=0 -> DONE next cycle, no mem_we; start with num_words=65 -> error=1, done=1, no mem_we.
REQ-040 start with num_words=64 and full stream -> last write at mem_addr=252; mem_addr then wraps to 0; done=1.
REQ-041 rst=0 after 2 bytes of word 1 -> next cycle IDLE, cpu_hold=1, done=0, no write; a fresh start then writes word 0 at address 0.
REQ-042 start pulsed during RECV -> ignored: num_words unchanged and addresses continue in sequence.
